// File: rtl/clk_pulse_pkg.sv
// Shared definitions for the clock-pulse family: FSM state encoding and default widths.
package clk_pulse_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALIGN = 2'd1,
      ST_HIGH  = 2'd2,
      ST_GUARD = 2'd3
   } state_t;

   localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/pulse_stretcher_if.sv
// Request/status bundle of the pulse stretcher: timebase, start request and generated level.
interface pulse_stretcher_if
   import clk_pulse_pkg::*;
#(
   parameter int CNT_W = DEFAULT_CNT_W
);

   logic             tick;
   logic             start;
   logic [CNT_W-1:0] duration;
   logic             out_level;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output tick, start, duration,
      input  out_level, busy, done, err
   );

   modport slave (
      input  tick, start, duration,
      output out_level, busy, done, err
   );

endinterface

// File: rtl/tick_downcounter.sv
// Loadable down-counter advanced by a tick enable; saturates at 1 so it never wraps.
module tick_downcounter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             tick_en,
   output logic             last
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // load has priority so a reload in the same cycle as a tick discards the decrement
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (tick_en && (cnt_q > CNT_W'(1))) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pulse_stretcher.sv
// Turns a one-cycle start strobe into a tick-aligned output level lasting a programmable
// number of tick intervals, followed by a guaranteed one-tick low guard.
//
// state | meaning
// IDLE  | waiting for start; tick ignored
// ALIGN | start accepted, waiting for the first tick to raise out_level
// HIGH  | out_level high, counting ticks down
// GUARD | out_level low, holding busy for one more tick interval
module pulse_stretcher
   import clk_pulse_pkg::*;
#(
   parameter int CNT_W     = DEFAULT_CNT_W,
   parameter bit RETRIGGER = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   pulse_stretcher_if.slave   bus
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] dur_q, dur_d;
   logic             out_q, out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             cnt_load;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_tick;
   logic             cnt_last;
   logic             dur_nz;
   logic             retrig;

   assign dur_nz = |bus.duration;
   assign retrig = bus.start && RETRIGGER && dur_nz;

   always_comb begin
      state_d  = state_q;
      dur_d    = dur_q;
      out_d    = out_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      cnt_load = 1'b0;
      cnt_val  = dur_q;
      cnt_tick = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               if (dur_nz) begin
                  dur_d   = bus.duration;
                  busy_d  = 1'b1;
                  state_d = ST_ALIGN;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_ALIGN: begin
            if (retrig) begin
               dur_d = bus.duration;
            end else if (bus.start) begin
               err_d = 1'b1;
            end
            if (bus.tick) begin
               out_d    = 1'b1;
               cnt_load = 1'b1;
               cnt_val  = dur_d;
               state_d  = ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (retrig) begin
               cnt_load = 1'b1;
               cnt_val  = bus.duration;
            end else begin
               err_d = bus.start;
               if (bus.tick) begin
                  if (cnt_last) begin
                     out_d   = 1'b0;
                     state_d = ST_GUARD;
                  end else begin
                     cnt_tick = 1'b1;
                  end
               end
            end
         end
         ST_GUARD: begin
            err_d = bus.start;
            if (bus.tick) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         dur_q   <= '0;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dur_q   <= dur_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   tick_downcounter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .tick_en  (cnt_tick),
      .last     (cnt_last)
   );

   assign bus.out_level = out_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;

endmodule
